// File: rtl/mm_red_tail_pkg.sv
// Shared widths, default modulus and word types for the Montgomery reduction tail.
package mm_pkg;

    localparam int QW = 64;
    localparam int TW = 256;
    localparam int RW = TW - QW;

    localparam logic [RW-1:0] MOD_P192 =
        192'hffffffff_ffffffff_ffffffff_fffffffe_ffffffff_ffffffff;

    typedef logic [RW-1:0] residue_t;
    typedef logic [TW-1:0] word_t;

endpackage

// File: rtl/mm_red_tail_if.sv
// Input (t/qp) and output (residue) handshake bundle of mm_red_tail.
interface mm_red_tail_if;
    import mm_pkg::*;

    logic     t_valid;
    logic     t_ready;
    word_t    t_data;
    word_t    qp_data;
    logic     out_valid;
    logic     out_ready;
    residue_t out_data;
    logic     lowbits_err;

    modport master (
        output t_valid, t_data, qp_data, out_ready,
        input  t_ready, out_valid, out_data, lowbits_err
    );

    modport slave (
        input  t_valid, t_data, qp_data, out_ready,
        output t_ready, out_valid, out_data, lowbits_err
    );

endinterface

// File: rtl/mm_red_fifo.sv
// Synchronous FIFO with exposed occupancy; head entry reads as zero when empty.
module mm_red_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [W-1:0]               wr_data,
    input  logic                       rd_en,
    output logic [W-1:0]               rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Pointers wrap modulo DEPTH so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= ptr_next(wr_ptr);
            if (rd_en) rd_ptr <= ptr_next(rd_ptr);
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/mm_red_tail.sv
// Montgomery word-reduction tail: (t + q*MOD) >> QW, conditional subtract, credit-gated FIFO.
// Define MM_RED_LOWCHK_EN to build the sticky nonzero-low-word checker (lowbits_err).
module mm_red_tail
    import mm_pkg::*;
#(
    parameter int       QP_LAT = 1,
    parameter int       DEPTH  = 4,
    parameter residue_t MOD    = MOD_P192
) (
    input  logic           clk,
    input  logic           rst,
    mm_red_tail_if.slave   bus
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] inflight;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   credit_used;
    logic          t_ready;
    logic          acc;
    logic          deq;

    // u < 2*MOD is guaranteed by the input precondition, so one subtract suffices.
    function automatic residue_t mod_reduce(input logic [RW:0] u);
        residue_t diff;
        diff = u[RW-1:0] - MOD;
        return (u >= {1'b0, MOD}) ? diff : u[RW-1:0];
    endfunction

    assign credit_used  = {1'b0, inflight} + {1'b0, fifo_count};
    assign t_ready      = !rst && (credit_used < (CW+1)'(DEPTH));
    assign acc          = bus.t_valid && t_ready;
    assign bus.t_ready  = t_ready;

    // ---- p0: delay line aligning t with the multiplier's qp output
    word_t             t_p0 [QP_LAT];
    logic [QP_LAT-1:0] vld_p0;

    always_ff @(posedge clk) begin
        t_p0[0] <= bus.t_data;
        for (int i = 1; i < QP_LAT; i++) t_p0[i] <= t_p0[i-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= '0;
        end else begin
            vld_p0[0] <= acc;
            for (int i = 1; i < QP_LAT; i++) vld_p0[i] <= vld_p0[i-1];
        end
    end

    // ---- p1: add t + qp and drop the low word, keeping only its carry
    logic [QW-1:0] lo_a;
    logic          cy_a;
    logic [RW:0]   u_a;
    logic [RW:0]   u_p1;
    logic          vld_p1;

    assign lo_a = t_p0[QP_LAT-1][QW-1:0] + bus.qp_data[QW-1:0];
    assign cy_a = (lo_a < t_p0[QP_LAT-1][QW-1:0]);
    assign u_a  = {1'b0, t_p0[QP_LAT-1][TW-1:QW]} + {1'b0, bus.qp_data[TW-1:QW]}
                + {{RW{1'b0}}, cy_a};

    always_ff @(posedge clk) begin
        if (vld_p0[QP_LAT-1]) u_p1 <= u_a;
    end

    always_ff @(posedge clk) begin
        if (rst) vld_p1 <= 1'b0;
        else     vld_p1 <= vld_p0[QP_LAT-1];
    end

`ifdef MM_RED_LOWCHK_EN
    logic lowbits_q;

    always_ff @(posedge clk) begin
        if (rst)                                   lowbits_q <= 1'b0;
        else if (vld_p0[QP_LAT-1] && lo_a != '0)   lowbits_q <= 1'b1;
    end

    assign bus.lowbits_err = lowbits_q;
`else
    assign bus.lowbits_err = 1'b0;
`endif

    // ---- p2: reduced residue written straight into the output FIFO
    residue_t r_p2;

    assign r_p2 = mod_reduce(u_p1);

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({acc, vld_p1})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    assign bus.out_valid = (fifo_count != '0);
    assign deq           = bus.out_valid && bus.out_ready;

    mm_red_fifo #(
        .W     (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (vld_p1),
        .wr_data (r_p2),
        .rd_en   (deq),
        .rd_data (bus.out_data),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_mm_red_tail.sv
// Directed bench for mm_red_tail with a scoreboard queue of expected residues.
module tb_mm_red_tail;
    import mm_pkg::*;

    localparam int DEPTH = 4;
`ifdef MM_RED_LOWCHK_EN
    localparam logic LOWCHK = 1'b1;
`else
    localparam logic LOWCHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mm_red_tail_if bus();

    mm_red_tail #(.QP_LAT(1), .DEPTH(DEPTH), .MOD(MOD_P192)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int       checks = 0;
    int       errors = 0;
    residue_t sb [$];
    word_t    qp_in;
    logic     stall_q = 1'b0;
    residue_t held;

    function automatic residue_t model(input word_t t, input word_t qp);
        logic [TW:0] s;
        logic [RW:0] u;
        s = {1'b0, t} + {1'b0, qp};
        u = s[TW:QW];
        if (u >= {1'b0, MOD_P192}) u = u - {1'b0, MOD_P192};
        return u[RW-1:0];
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Multiplier model: qp follows the accepted t by one cycle; expectations pushed on accept.
    always @(posedge clk) begin
        if (rst) sb.delete();
        else if (bus.t_valid && bus.t_ready) sb.push_back(model(bus.t_data, qp_in));
        bus.qp_data <= (bus.t_valid && bus.t_ready) ? qp_in : '0;
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("credit_bound", sb.size() <= DEPTH, 1);
            if (stall_q) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_data", bus.out_data, held);
            end
            if (bus.out_valid && bus.out_ready) begin
                chk("out_expected", sb.size() != 0, 1);
                if (sb.size() != 0) chk("out_data", bus.out_data, sb.pop_front());
            end
            stall_q <= bus.out_valid && !bus.out_ready;
            held    <= bus.out_data;
        end else begin
            stall_q <= 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input word_t t, input word_t qp);
        bit acc;
        int n;
        n = 0;
        bus.t_valid = 1'b1;
        bus.t_data  = t;
        qp_in       = qp;
        do begin
            @(negedge clk);
            acc = bus.t_ready;
            step();
            n++;
        end while (!acc && n < 50);
        chk("send_accepted", acc, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.t_valid = 1'b0;
        while (sb.size() != 0 && n < 100) begin
            step();
            n++;
        end
        step();
        chk("drained", sb.size(), 0);
        chk("drained_out_valid", bus.out_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bus.t_valid   = 1'b0;
        bus.t_data    = '0;
        bus.out_ready = 1'b1;
        qp_in         = '0;

        // Reset state
        rst = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("rst_t_ready", bus.t_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_lowbits", bus.lowbits_err, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", bus.t_ready, 1);
        step();

        // Zero input and latency
        send('0, '0);
        bus.t_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 10);
        chk("latency", lat, 3);
        step();
        drain();
        chk("lowbits_zero", bus.lowbits_err, 0);

        // Shift and subtract paths
        send({192'd1, 64'd0}, '0);
        send({MOD_P192, 64'd0}, '0);
        send({MOD_P192 - 192'd1, 64'd0}, {192'd2, 64'd0});
        send({MOD_P192 - 192'd1, 64'd0}, {MOD_P192 - 192'd1, 64'd0});
        drain();

        // Low-word carry, then nonzero low word
        send({192'd0, 64'd1}, {192'd0, 64'hffff_ffff_ffff_ffff});
        drain();
        chk("lowbits_carry", bus.lowbits_err, 0);
        send({192'd0, 64'd1}, '0);
        drain();
        chk("lowbits_set", bus.lowbits_err, LOWCHK);

        // Back-pressure: exactly DEPTH accepted while stalled
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) send({192'(k), 64'd0}, '0);
        bus.t_data = {192'd5, 64'd0};
        qp_in      = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("full_t_ready", bus.t_ready, 0);
            chk("full_out_valid", bus.out_valid, 1);
            step();
        end
        chk("full_outstanding", sb.size(), 4);
        bus.out_ready = 1'b1;
        send({192'd5, 64'd0}, '0);
        send({192'd6, 64'd0}, '0);
        drain();

        // Streaming with toggling out_ready
        fork
            begin
                for (int k = 0; k < 10; k++)
                    send({192'((k + 10) * 3), 64'h5}, {192'(k), 64'hffff_ffff_ffff_fffb});
                bus.t_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    bus.out_ready = (i % 2 == 0);
                    step();
                end
            end
        join
        bus.out_ready = 1'b1;
        drain();
        chk("lowbits_sticky", bus.lowbits_err, LOWCHK);

        // Reset with two queued and two in flight
        bus.out_ready = 1'b0;
        for (int k = 21; k <= 24; k++) send({192'(k), 64'd0}, {192'(k), 64'd0});
        rst         = 1'b1;
        bus.t_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_out_valid", bus.out_valid, 1);
        step();
        @(negedge clk);
        chk("in_rst_out_valid", bus.out_valid, 0);
        chk("in_rst_t_ready", bus.t_ready, 0);
        step();
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_t_ready", bus.t_ready, 1);
        for (int i = 0; i < 6; i++) begin
            step();
            @(negedge clk);
            chk("post_rst_no_out", bus.out_valid, 0);
        end
        chk("post_rst_lowbits", bus.lowbits_err, 0);
        chk("post_rst_sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
